// File: rtl/uart2bus_pkg.sv
// Shared types, defaults and the round-robin selection function for the uart2bus
// register-bus arbiter.
package uart2bus_pkg;

  typedef logic [1:0] arb_state_e;

  localparam arb_state_e IDLE   = 2'd0;
  localparam arb_state_e GRANT  = 2'd1;
  localparam arb_state_e REVOKE = 2'd2;

  localparam int unsigned DEF_ADDR_W  = 16;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned MAX_MASTERS = 8;

  // First requester at or after ptr, wrapping modulo n; returns ptr when nobody requests.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n);
    logic        found;
    logic [2:0]  sel;
    int unsigned idx;
    found = 1'b0;
    sel   = ptr;
    for (int unsigned k = 0; k < MAX_MASTERS; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (!found && k < n && req[idx[2:0]]) begin
        sel   = idx[2:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/uart2bus_rr_picker.sv
// Combinational round-robin priority encoder: picks the first active request at or
// after ptr.
module uart2bus_rr_picker
  import uart2bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [2:0]             ptr,
  output logic [2:0]             sel,
  output logic                   any
);

  logic [7:0] req_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_MASTERS-1:0] = req;
  end

  assign sel = rr_pick(req_ext, ptr, NUM_MASTERS);
  assign any = |req;

endmodule

// File: rtl/uart2bus_bus_arbiter.sv
// Round-robin arbiter sharing the internal register bus between NUM_MASTERS requesters,
// with a watchdog that revokes grants held too long.
module uart2bus_bus_arbiter
  import uart2bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS-1:0]        m_read,
  output logic [DATA_W-1:0]             m_rd_data,
  output logic [ADDR_W-1:0]             s_address,
  output logic [DATA_W-1:0]             s_wr_data,
  output logic                          s_write,
  output logic                          s_read,
  input  logic [DATA_W-1:0]             s_rd_data,
  output logic [2:0]                    owner_id,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          proto_err
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state;
  logic [2:0]       owner;
  logic [2:0]       rr_ptr;
  logic [2:0]       next_ptr;
  logic [2:0]       pick_sel;
  logic             pick_any;
  logic             owner_req;
  logic             own_write;
  logic             own_read;
  logic [WD_W-1:0]  watchdog;

  uart2bus_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .req(m_req),
    .ptr(rr_ptr),
    .sel(pick_sel),
    .any(pick_any)
  );

  assign next_ptr  = (owner == 3'(NUM_MASTERS - 1)) ? 3'd0 : owner + 3'd1;
  assign busy      = (state == GRANT);
  assign owner_id  = owner;
  assign m_rd_data = s_rd_data;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      m_gnt       <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      watchdog    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= GRANT;
            owner    <= pick_sel;
            m_gnt    <= NUM_MASTERS'(1) << pick_sel;
            watchdog <= '0;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            m_gnt  <= '0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else if (watchdog == WD_LAST) begin
            m_gnt       <= '0;
            timeout_err <= 1'b1;
            rr_ptr      <= next_ptr;
            state       <= REVOKE;
          end else if (watchdog != '1) begin
            watchdog <= watchdog + 1'b1;
          end
        end
        REVOKE: begin
          // Everyone stays blocked until the revoked master lets go.
          if (!owner_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    owner_req = 1'b0;
    own_write = 1'b0;
    own_read  = 1'b0;
    s_address = '0;
    s_wr_data = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner == 3'(i)) begin
        owner_req = m_req[i];
        own_write = m_write[i];
        own_read  = m_read[i];
        if (busy) begin
          s_address = m_address[i*ADDR_W +: ADDR_W];
          s_wr_data = m_wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
    // Write wins when the owner drives both strobes.
    s_write   = busy & own_write;
    s_read    = busy & own_read & ~own_write;
    proto_err = busy & own_write & own_read;
  end

  a_gnt_onehot0 : assert property (@(posedge clock) disable iff (!reset) $onehot0(m_gnt));

endmodule
